// File: rtl/core.sv
// core: single-cycle 8-bit stack-machine CPU with internal instruction/data memories
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - synchronous active-low reset
//   init_PC - PC value loaded while reset is held
// Hierarchy kept stable for benches: cu.instruction_memory.mem, data_memory.mem,
// stack.mem, stack.sp, cu.pc, cu.halted.

package core_pkg;
  typedef enum logic [2:0] {ST_NONE, ST_PUSH, ST_POP, ST_BIN, ST_REP} stack_op_t;
endpackage

// instruction_memory: combinational-read program store, contents survive reset
// Ports: clk; i_we/i_waddr/i_wdata write port (tied off by the core); i_addr -> o_inst
module instruction_memory #(
  parameter int WORD_RANGE = 8,
  parameter int MEMORY_WORD_COUNT = 256,
  parameter int INST_RANGE = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [WORD_RANGE-1:0] i_waddr,
  input  logic [INST_RANGE-1:0] i_wdata,
  input  logic [WORD_RANGE-1:0] i_addr,
  output logic [INST_RANGE-1:0] o_inst
);
  logic [INST_RANGE-1:0] mem [0:MEMORY_WORD_COUNT-1];
  assign o_inst = mem[i_addr];
  always_ff @(posedge clk)
    if (i_we) mem[i_waddr] <= i_wdata;
endmodule

// data_memory: combinational-read, edge-written data store, cleared by reset
// Ports: clk, rst_n; i_addr shared by read and write; i_we/i_wdata write; o_rdata read
module data_memory #(
  parameter int WORD_RANGE = 8,
  parameter int MEMORY_WORD_COUNT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_RANGE-1:0] i_addr,
  input  logic                  i_we,
  input  logic [WORD_RANGE-1:0] i_wdata,
  output logic [WORD_RANGE-1:0] o_rdata
);
  logic [WORD_RANGE-1:0] mem [0:MEMORY_WORD_COUNT-1];
  assign o_rdata = mem[i_addr];
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < MEMORY_WORD_COUNT; i++) mem[i] <= '0;
    end else if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
endmodule

// stack: operand stack, sp counts valid entries; empty reads return 0
// Ports: clk, rst_n; i_op stack operation; i_wdata value pushed/written; o_t top, o_n below top
module stack
  import core_pkg::*;
#(
  parameter int WORD_RANGE = 8,
  parameter int STACK_WORD_COUNT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  stack_op_t             i_op,
  input  logic [WORD_RANGE-1:0] i_wdata,
  output logic [WORD_RANGE-1:0] o_t,
  output logic [WORD_RANGE-1:0] o_n
);
  localparam int SPW = $clog2(STACK_WORD_COUNT + 1);
  localparam int IW = $clog2(STACK_WORD_COUNT);
  logic [WORD_RANGE-1:0] mem [0:STACK_WORD_COUNT-1];
  logic [SPW-1:0] sp;
  logic [SPW-1:0] w_tm1, w_tm2;
  assign w_tm1 = sp - SPW'(1);
  assign w_tm2 = sp - SPW'(2);
  assign o_t = (sp != '0) ? mem[w_tm1[IW-1:0]] : '0;
  assign o_n = (sp >= SPW'(2)) ? mem[w_tm2[IW-1:0]] : '0;
  // Binary and replace ops pop their operands (empty pops yield 0) then push the
  // result, so on a short stack the result lands in entry 0 with sp ending at 1.
  always_ff @(posedge clk)
    if (!rst_n) begin
      sp <= '0;
      for (int i = 0; i < STACK_WORD_COUNT; i++) mem[i] <= '0;
    end else begin
      case (i_op)
        ST_PUSH: if (sp != SPW'(STACK_WORD_COUNT)) begin
          mem[sp[IW-1:0]] <= i_wdata;
          sp <= sp + SPW'(1);
        end
        ST_POP: if (sp != '0) sp <= w_tm1;
        ST_BIN: if (sp >= SPW'(2)) begin
          mem[w_tm2[IW-1:0]] <= i_wdata;
          sp <= w_tm1;
        end else begin
          mem[0] <= i_wdata;
          sp <= SPW'(1);
        end
        ST_REP: if (sp != '0) mem[w_tm1[IW-1:0]] <= i_wdata;
        else begin
          mem[0] <= i_wdata;
          sp <= SPW'(1);
        end
        default: ;
      endcase
    end
endmodule

// cu: fetch, decode, ALU, PC sequencing and halt flag
// Ports: clk, rst_n, init_PC; i_t/i_n stack operands; i_dm_rdata data read;
//        o_op/o_wdata stack control; o_addr data address; o_dm_we data write enable
module cu
  import core_pkg::*;
#(
  parameter int WORD_RANGE = 8,
  parameter int MEMORY_WORD_COUNT = 256,
  parameter int INST_RANGE = 12,
  parameter int OP_CODE_RANGE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_RANGE-1:0] init_PC,
  input  logic [WORD_RANGE-1:0] i_t,
  input  logic [WORD_RANGE-1:0] i_n,
  input  logic [WORD_RANGE-1:0] i_dm_rdata,
  output stack_op_t             o_op,
  output logic [WORD_RANGE-1:0] o_wdata,
  output logic [WORD_RANGE-1:0] o_addr,
  output logic                  o_dm_we
);
  logic [WORD_RANGE-1:0] pc;
  logic halted;
  logic [INST_RANGE-1:0] w_inst;
  logic [OP_CODE_RANGE-1:0] w_opc;
  logic [WORD_RANGE-1:0] w_arg, w_pc_next;
  logic w_halt;
  instruction_memory #(
    .WORD_RANGE(WORD_RANGE), .MEMORY_WORD_COUNT(MEMORY_WORD_COUNT), .INST_RANGE(INST_RANGE)
  ) instruction_memory (
    .clk(clk), .i_we(1'b0), .i_waddr('0), .i_wdata('0), .i_addr(pc), .o_inst(w_inst)
  );
  assign w_opc = w_inst[INST_RANGE-1 -: OP_CODE_RANGE];
  assign w_arg = w_inst[WORD_RANGE-1:0];
  assign o_addr = w_arg;
  // While halted every control output stays at its idle default.
  always_comb begin
    o_op = ST_NONE;
    o_wdata = '0;
    o_dm_we = 1'b0;
    w_pc_next = pc + WORD_RANGE'(1);
    w_halt = 1'b0;
    if (!halted)
      case (w_opc)
        4'h0: begin o_op = ST_PUSH; o_wdata = w_arg; end
        4'h1: begin o_op = ST_PUSH; o_wdata = i_dm_rdata; end
        4'h2: begin o_op = ST_POP; o_dm_we = 1'b1; end
        4'h3: w_pc_next = w_arg;
        4'h4: begin o_op = ST_POP; w_pc_next = (i_t == '0) ? w_arg : w_pc_next; end
        4'h5: begin o_op = ST_PUSH; o_wdata = i_t; end
        4'h6: begin o_op = ST_BIN; o_wdata = i_n + i_t; end
        4'h7: begin o_op = ST_BIN; o_wdata = i_t - i_n; end
        4'h8: begin o_op = ST_BIN; o_wdata = i_t & i_n; end
        4'h9: begin o_op = ST_BIN; o_wdata = i_t | i_n; end
        4'hA: begin o_op = ST_REP; o_wdata = ~i_t; end
        4'hF: begin w_halt = 1'b1; w_pc_next = pc; end
        default: ;
      endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      pc <= init_PC;
      halted <= 1'b0;
    end else if (!halted) begin
      pc <= w_pc_next;
      halted <= w_halt;
    end
endmodule

module core
  import core_pkg::*;
#(
  parameter int WORD_RANGE = 8,
  parameter int MEMORY_WORD_COUNT = 256,
  parameter int STACK_WORD_COUNT = 8,
  parameter int INST_RANGE = 12,
  parameter int OP_CODE_RANGE = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [WORD_RANGE-1:0] init_PC
);
  stack_op_t w_op;
  logic [WORD_RANGE-1:0] w_wdata, w_addr, w_t, w_n, w_rdata;
  logic w_dm_we;
  cu #(
    .WORD_RANGE(WORD_RANGE), .MEMORY_WORD_COUNT(MEMORY_WORD_COUNT),
    .INST_RANGE(INST_RANGE), .OP_CODE_RANGE(OP_CODE_RANGE)
  ) cu (
    .clk(clk), .rst_n(rst_n), .init_PC(init_PC), .i_t(w_t), .i_n(w_n), .i_dm_rdata(w_rdata),
    .o_op(w_op), .o_wdata(w_wdata), .o_addr(w_addr), .o_dm_we(w_dm_we)
  );
  stack #(.WORD_RANGE(WORD_RANGE), .STACK_WORD_COUNT(STACK_WORD_COUNT)) stack (
    .clk(clk), .rst_n(rst_n), .i_op(w_op), .i_wdata(w_wdata), .o_t(w_t), .o_n(w_n)
  );
  // POP stores T, which already reads as 0 on an empty stack.
  data_memory #(.WORD_RANGE(WORD_RANGE), .MEMORY_WORD_COUNT(MEMORY_WORD_COUNT)) data_memory (
    .clk(clk), .rst_n(rst_n), .i_addr(w_addr), .i_we(w_dm_we), .i_wdata(w_t), .o_rdata(w_rdata)
  );
endmodule

// File: tb/tb_core.sv
// tb_core: scoreboard bench for the stack-machine core
module tb_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] init_PC = 8'h00;
  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  core dut(.clk(clk), .rst_n(rst_n), .init_PC(init_PC));

  always #5 clk = ~clk;

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.cu.instruction_memory.mem[i] = 12'hB00;
  endtask

  task automatic do_reset(input logic [7:0] pc0);
    init_PC = pc0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] top();
    logic [3:0] s;
    s = dut.stack.sp - 4'd1;
    return (dut.stack.sp == 4'd0) ? 8'h00 : dut.stack.mem[s[2:0]];
  endfunction

  task automatic test_reset();
    clear_imem();
    dut.data_memory.mem[5] = 8'hAA;
    dut.stack.mem[3] = 8'h5A;
    exp_q.push_back(8'h40); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    do_reset(8'h40);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", dut.cu.pc, e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL reset_sp got=%h exp=%h", dut.stack.sp, e); end
    e = exp_q.pop_front(); n_cmp++; if ({7'h0, dut.cu.halted} !== e) begin n_fail++; $display("FAIL reset_halted got=%b exp=%h", dut.cu.halted, e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[5] !== e) begin n_fail++; $display("FAIL reset_dmem got=%h exp=%h", dut.data_memory.mem[5], e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.stack.mem[3] !== e) begin n_fail++; $display("FAIL reset_stack got=%h exp=%h", dut.stack.mem[3], e); end
  endtask

  task automatic test_expression();
    logic [11:0] prog [0:10] = '{12'h03D, 12'h200, 12'h00F, 12'h06C, 12'h600, 12'h201,
                                 12'h101, 12'h07D, 12'h700, 12'h202, 12'hF00};
    clear_imem();
    for (int i = 0; i < 11; i++) dut.cu.instruction_memory.mem[i] = prog[i];
    exp_q.push_back(8'h3D); exp_q.push_back(8'h7B); exp_q.push_back(8'h02);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h0A); exp_q.push_back(8'h0A);
    do_reset(8'h00);
    run(11);
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[0] !== e) begin n_fail++; $display("FAIL expr_mem0 got=%h exp=%h", dut.data_memory.mem[0], e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[1] !== e) begin n_fail++; $display("FAIL expr_mem1 got=%h exp=%h", dut.data_memory.mem[1], e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[2] !== e) begin n_fail++; $display("FAIL expr_mem2 got=%h exp=%h", dut.data_memory.mem[2], e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL expr_sp got=%h exp=%h", dut.stack.sp, e); end
    e = exp_q.pop_front(); n_cmp++; if ({7'h0, dut.cu.halted} !== e) begin n_fail++; $display("FAIL expr_halted got=%b exp=%h", dut.cu.halted, e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL expr_pc got=%h exp=%h", dut.cu.pc, e); end
    run(3);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL halt_hold_pc got=%h exp=%h", dut.cu.pc, e); end
  endtask

  task automatic test_wrap();
    logic [11:0] prog [0:6] = '{12'h0F0, 12'h020, 12'h600, 12'h005, 12'h003, 12'h700, 12'hF00};
    clear_imem();
    for (int i = 0; i < 7; i++) dut.cu.instruction_memory.mem[i] = prog[i];
    exp_q.push_back(8'h10); exp_q.push_back(8'h01); exp_q.push_back(8'hFE); exp_q.push_back(8'h02);
    do_reset(8'h00);
    run(3);
    e = exp_q.pop_front(); n_cmp++; if (top() !== e) begin n_fail++; $display("FAIL add_wrap got=%h exp=%h", top(), e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL add_sp got=%h exp=%h", dut.stack.sp, e); end
    run(3);
    e = exp_q.pop_front(); n_cmp++; if (top() !== e) begin n_fail++; $display("FAIL sub_wrap got=%h exp=%h", top(), e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL sub_sp got=%h exp=%h", dut.stack.sp, e); end
  endtask

  task automatic test_stack_bounds();
    clear_imem();
    for (int i = 0; i < 9; i++) dut.cu.instruction_memory.mem[i] = 12'(i + 1);
    dut.cu.instruction_memory.mem[9] = 12'hF00;
    exp_q.push_back(8'h08); exp_q.push_back(8'h08);
    do_reset(8'h00);
    run(10);
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL full_sp got=%h exp=%h", dut.stack.sp, e); end
    e = exp_q.pop_front(); n_cmp++; if (top() !== e) begin n_fail++; $display("FAIL full_top got=%h exp=%h", top(), e); end
    clear_imem();
    dut.cu.instruction_memory.mem[0] = 12'h210;
    dut.cu.instruction_memory.mem[1] = 12'h211;
    dut.cu.instruction_memory.mem[2] = 12'hF00;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    do_reset(8'h00);
    dut.data_memory.mem[8'h10] = 8'h55;
    dut.data_memory.mem[8'h11] = 8'h66;
    run(3);
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[8'h10] !== e) begin n_fail++; $display("FAIL empty_pop0 got=%h exp=%h", dut.data_memory.mem[8'h10], e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[8'h11] !== e) begin n_fail++; $display("FAIL empty_pop1 got=%h exp=%h", dut.data_memory.mem[8'h11], e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL empty_sp got=%h exp=%h", dut.stack.sp, e); end
  endtask

  task automatic test_control();
    clear_imem();
    dut.cu.instruction_memory.mem[8'h00] = 12'h000;
    dut.cu.instruction_memory.mem[8'h01] = 12'h420;
    dut.cu.instruction_memory.mem[8'h20] = 12'h001;
    dut.cu.instruction_memory.mem[8'h21] = 12'h430;
    dut.cu.instruction_memory.mem[8'h22] = 12'h3FF;
    dut.cu.instruction_memory.mem[8'hFF] = 12'hB00;
    exp_q.push_back(8'h20); exp_q.push_back(8'h00); exp_q.push_back(8'h22);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    do_reset(8'h00);
    run(2);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL jz_taken_pc got=%h exp=%h", dut.cu.pc, e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL jz_pop_sp got=%h exp=%h", dut.stack.sp, e); end
    run(2);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL jz_not_taken_pc got=%h exp=%h", dut.cu.pc, e); end
    run(1);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL jmp_pc got=%h exp=%h", dut.cu.pc, e); end
    run(1);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL pc_wrap got=%h exp=%h", dut.cu.pc, e); end
  endtask

  task automatic test_init_pc();
    clear_imem();
    dut.cu.instruction_memory.mem[8'h00] = 12'hF00;
    dut.cu.instruction_memory.mem[8'h40] = 12'h077;
    dut.cu.instruction_memory.mem[8'h41] = 12'h203;
    dut.cu.instruction_memory.mem[8'h42] = 12'hF00;
    exp_q.push_back(8'h77); exp_q.push_back(8'h01); exp_q.push_back(8'h42);
    exp_q.push_back(8'h00); exp_q.push_back(8'h40);
    do_reset(8'h40);
    run(3);
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[3] !== e) begin n_fail++; $display("FAIL init_mem3 got=%h exp=%h", dut.data_memory.mem[3], e); end
    e = exp_q.pop_front(); n_cmp++; if ({7'h0, dut.cu.halted} !== e) begin n_fail++; $display("FAIL init_halted got=%b exp=%h", dut.cu.halted, e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL init_pc got=%h exp=%h", dut.cu.pc, e); end
    do_reset(8'h40);
    e = exp_q.pop_front(); n_cmp++; if ({7'h0, dut.cu.halted} !== e) begin n_fail++; $display("FAIL halt_reset_halted got=%b exp=%h", dut.cu.halted, e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL halt_reset_pc got=%h exp=%h", dut.cu.pc, e); end
  endtask

  task automatic test_mid_reset();
    logic [11:0] prog [0:4] = '{12'h009, 12'h204, 12'h001, 12'h002, 12'h344};
    clear_imem();
    for (int i = 0; i < 5; i++) dut.cu.instruction_memory.mem[8'h40 + i] = prog[i];
    exp_q.push_back(8'h09); exp_q.push_back(8'h02);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h41); exp_q.push_back(8'h09);
    do_reset(8'h40);
    run(6);
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[4] !== e) begin n_fail++; $display("FAIL mid_pre_mem4 got=%h exp=%h", dut.data_memory.mem[4], e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL mid_pre_sp got=%h exp=%h", dut.stack.sp, e); end
    do_reset(8'h40);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL mid_pc got=%h exp=%h", dut.cu.pc, e); end
    e = exp_q.pop_front(); n_cmp++; if ({4'h0, dut.stack.sp} !== e) begin n_fail++; $display("FAIL mid_sp got=%h exp=%h", dut.stack.sp, e); end
    e = exp_q.pop_front(); n_cmp++; if (dut.data_memory.mem[4] !== e) begin n_fail++; $display("FAIL mid_mem4 got=%h exp=%h", dut.data_memory.mem[4], e); end
    run(1);
    e = exp_q.pop_front(); n_cmp++; if (dut.cu.pc !== e) begin n_fail++; $display("FAIL mid_restart_pc got=%h exp=%h", dut.cu.pc, e); end
    e = exp_q.pop_front(); n_cmp++; if (top() !== e) begin n_fail++; $display("FAIL mid_restart_top got=%h exp=%h", top(), e); end
  endtask

  initial begin
    test_reset();
    test_expression();
    test_wrap();
    test_stack_bounds();
    test_control();
    test_init_pc();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
